// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, bo set when the bit borrows.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  logic w_xy;

  assign w_xy = x ^ y;
  assign d    = w_xy ^ bi;
  assign bo   = (~x & y) | (~w_xy & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// with a start/busy/done handshake that allows back-to-back operations.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_brw;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_d;
  logic             w_bo;

  full_subtractor u_fs (
    .x  (r_a_sh[0]),
    .y  (r_b_sh[0]),
    .bi (r_brw),
    .d  (w_d),
    .bo (w_bo)
  );

  assign w_last = (r_count == LAST_BIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // start is only honoured when no bits are in flight
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_SHIFT;
          w_accept     = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_state_next = S_SHIFT;
          w_accept     = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_brw   <= 1'b0;
      r_count <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_brw   <= bin;
      r_count <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      // each result bit enters at the MSB so the LSB ends up at bit 0
      r_diff  <= {w_d, r_diff[WIDTH-1:1]};
      r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_brw   <= w_bo;
      r_count <= r_count + 1'b1;
      if (w_last) begin
        r_bout <= w_bo;
      end
    end
  end

  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);
  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed cases plus random
// operations compared against an integer-arithmetic reference.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int n_checks;
  int n_fail;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: plain signed arithmetic, result taken modulo 2^W
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                       output logic [W-1:0] md, output logic mb);
    int r;
    r  = int'(ta) - int'(tb_v) - int'(tbin);
    mb = (r < 0);
    md = W'((r + (1 << (W + 1))) % (1 << W));
  endtask

  // Called at a negedge; returns at the negedge where done is high (still in the DONE cycle).
  // inject>0 pulses a stray start (a=1,b=1) at that cycle count while busy.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                       input logic [W-1:0] ed, input logic eb, input int inject, input string tag);
    int   cyc;
    logic seen;
    a = ta; b = tb_v; bin = tbin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    cyc  = 1;
    seen = 1'b0;
    while (cyc <= 12) begin
      @(negedge clk);
      if (cyc == 1) chk({tag, "_busy"}, busy, 1);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (inject > 0 && cyc == inject) begin
        start = 1'b1; a = 4'b0001; b = 4'b0001;
      end else if (inject > 0 && cyc == inject + 1) begin
        start = 1'b0;
      end
      @(posedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_latency"}, cyc, 5);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, bout, eb);
    $display("op %s a=%b b=%b bin=%b -> diff=%b bout=%b (exp %b/%b) lat=%0d",
             tag, ta, tb_v, tbin, diff, bout, ed, eb, cyc);
  endtask

  initial begin
    logic [W-1:0] md, ra, rb;
    logic         mb, rbin;
    int           pulses;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    rst = 1'b0;
    @(negedge clk);

    do_op(4'b0110, 4'b1100, 1'b0, 4'b1010, 1'b1, 0, "ex1");
    @(negedge clk);
    chk("idle_hold_diff", diff, 4'b1010);
    chk("idle_hold_done", done, 0);
    do_op(4'b1110, 4'b1000, 1'b0, 4'b0110, 1'b0, 0, "ex2");
    @(negedge clk);

    // back to back: second start issued in the first op's DONE cycle
    do_op(4'b0111, 4'b1110, 1'b0, 4'b1001, 1'b1, 0, "b2b_1");
    do_op(4'b0010, 4'b1001, 1'b0, 4'b1001, 1'b1, 0, "b2b_2");
    @(negedge clk);

    do_op(4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 0, "bin1");
    @(negedge clk);
    do_op(4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 0, "max");
    @(negedge clk);

    // stray start mid-operation must be ignored; only one done pulse
    do_op(4'b0110, 4'b1100, 1'b0, 4'b1010, 1'b1, 2, "ignore");
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("ignore_extra_done", pulses, 0);
    chk("ignore_idle_busy", busy, 0);

    // reset two cycles into an operation
    a = 4'b0110; b = 4'b1100; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    do_op(4'b1110, 4'b1000, 1'b0, 4'b0110, 1'b0, 0, "after_abort");
    @(negedge clk);

    // random operations, alternating idle gaps and back-to-back issue
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      model(ra, rb, rbin, md, mb);
      do_op(ra, rb, rbin, md, mb, 0, "rand");
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
